mem_arbiter: RTL

Arbiter and sequencer that shares the single main-memory port between instruction-cache and data-cache line transfers in the multicycle processor. It is triggered by cache misses (`ihit`/`dhit` low), grants one requester at a time with two-way round-robin priority, and walks a fixed-length burst of `LINE_WORDS` word beats through a ready handshake. It reports per-beat data and a completion pulse back to the owning cache. It sits between the two caches and the memory model; the controller stalls on `busy`.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arbiter_rr_pick2.sv | 28 ++
 rtl/mem_arbiter.sv | 107 ++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the instruction/data cache memory-port arbiter:
// FSM state encoding, owner identifiers and line-offset sizing.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_XFER_I = 2'b01;
    localparam logic [1:0] ST_XFER_D = 2'b10;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Number of byte-address bits covered by one cache line.
    function automatic int line_off_w(input int line_words, input int data_w);
        return $clog2(line_words * (data_w / 8));
    endfunction

    localparam int LINE_OFF_W_DEFAULT = line_off_w(4, 32);

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of I-cache, D-cache and memory-port signals around the arbiter.
// master is the arbiter's view, slave is the caches/memory view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEAT_W = 2
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic [DATA_W-1:0] ic_rdata;
    logic              ic_rvalid;
    logic              ic_done;

    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic [BEAT_W-1:0] dc_beat;
    logic [DATA_W-1:0] dc_rdata;
    logic              dc_rvalid;
    logic              dc_done;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport master (
        input  ic_req, ic_addr,
        output ic_rdata, ic_rvalid, ic_done,
        input  dc_req, dc_we, dc_addr, dc_wdata,
        output dc_beat, dc_rdata, dc_rvalid, dc_done,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata,
        output busy
    );

    modport slave (
        output ic_req, ic_addr,
        input  ic_rdata, ic_rvalid, ic_done,
        output dc_req, dc_we, dc_addr, dc_wdata,
        input  dc_beat, dc_rdata, dc_rvalid, dc_done,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata,
        input  busy
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: one-hot grant indexed by owner id, the
// requester not granted last wins a tie.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // Grant selection from request pattern and previous winner.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if (last == OWN_I) begin
                    grant = 2'b10;
                end else begin
                    grant = 2'b01;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory port between I-cache refills and D-cache
// refills/writebacks, sequencing one fixed-length burst per grant.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);

    localparam int BEAT_W  = $clog2(LINE_WORDS);
    localparam int OFF_W   = line_off_w(LINE_WORDS, DATA_W);
    localparam int WORD_SH = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] BASE_MASK =
        ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    logic [1:0]        state_r;
    logic [1:0]        state_s;
    logic              last_r;
    logic [ADDR_W-1:0] base_r;
    logic              we_r;
    logic [BEAT_W-1:0] beat_r;
    logic [1:0]        grant_s;
    logic [ADDR_W-1:0] grant_addr_s;
    logic              xfer_s;
    logic              beat_done_s;
    logic              last_beat_s;

    rr_pick2 u_pick (
        .req   ({bus.dc_req, bus.ic_req}),
        .last  (last_r),
        .grant (grant_s)
    );

    assign grant_addr_s = grant_s[OWN_D] ? bus.dc_addr : bus.ic_addr;
    assign xfer_s       = (state_r == ST_XFER_I) || (state_r == ST_XFER_D);
    assign beat_done_s  = xfer_s && bus.mem_ready;
    assign last_beat_s  = beat_done_s && (beat_r == LAST_BEAT);

    // Next-state selection: grant from IDLE, return after the final beat.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s[OWN_D]) begin
                    state_s = ST_XFER_D;
                end else if (grant_s[OWN_I]) begin
                    state_s = ST_XFER_I;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_XFER_I, ST_XFER_D: begin
                if (last_beat_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, grant latches and beat counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            last_r  <= OWN_I;
            base_r  <= {ADDR_W{1'b0}};
            we_r    <= 1'b0;
            beat_r  <= {BEAT_W{1'b0}};
        end else begin
            state_r <= state_s;
            if ((state_r == ST_IDLE) && (grant_s != 2'b00)) begin
                base_r <= grant_addr_s & BASE_MASK;
                we_r   <= grant_s[OWN_D] & bus.dc_we;
                beat_r <= {BEAT_W{1'b0}};
                last_r <= grant_s[OWN_D] ? OWN_D : OWN_I;
            end else if (beat_done_s) begin
                // Power-of-two line length makes the natural wrap land on 0.
                beat_r <= beat_r + BEAT_W'(1);
            end
        end
    end

    assign bus.busy      = (state_r != ST_IDLE);
    assign bus.mem_req   = xfer_s;
    assign bus.mem_we    = xfer_s && we_r;
    assign bus.mem_addr  = xfer_s ? (base_r + (ADDR_W'(beat_r) << WORD_SH))
                                  : {ADDR_W{1'b0}};
    assign bus.mem_wdata = ((state_r == ST_XFER_D) && we_r) ? bus.dc_wdata
                                                            : {DATA_W{1'b0}};
    assign bus.dc_beat   = beat_r;

    assign bus.ic_rdata  = bus.mem_rdata;
    assign bus.dc_rdata  = bus.mem_rdata;
    assign bus.ic_rvalid = (state_r == ST_XFER_I) && beat_done_s && !we_r;
    assign bus.dc_rvalid = (state_r == ST_XFER_D) && beat_done_s && !we_r;
    assign bus.ic_done   = (state_r == ST_XFER_I) && last_beat_s;
    assign bus.dc_done   = (state_r == ST_XFER_D) && last_beat_s;

endmodule
